// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the Hamming(15,11) serial receiver:
//   - code geometry constants N (code bits), K (data bits), R (parity bits)
//   - POS_DADO: the 1-based codeword position that holds each data bit d[i]
//   - estado_t: receiver FSM state encoding
package hamming_pkg;

    localparam int N = 15;
    localparam int K = 11;
    localparam int R = 4;

    typedef logic [R-1:0] pos_t;

    // d[i] lives at codeword position POS_DADO[i], which is bit c[POS_DADO[i]-1].
    localparam pos_t POS_DADO [K] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        INICIO  = 3'd1,
        DADOS   = 3'd2,
        PARADA  = 3'd3,
        CORRIGE = 3'd4
    } estado_t;

endpackage

// File: rtl/sindrome_hamming.sv
// sindrome_hamming
// Combinational Hamming(15,11) decoder.
//   c         in  15  received codeword, c[p-1] holds position p
//   s         out 4   syndrome (XOR of the positions of all set bits)
//   d         out 11  data bits after single-bit correction
//   corrigido out 1   a non-zero syndrome was found and a bit was flipped
// Double errors alias onto a wrong single position and are silently
// miscorrected; this block does not try to detect them.
module sindrome_hamming
    import hamming_pkg::*;
(
    input  logic [N-1:0] c,
    output logic [R-1:0] s,
    output logic [K-1:0] d,
    output logic         corrigido
);

    logic [N-1:0] c_corr;

    always_comb begin
        s = '0;
        for (int p = 0; p < N; p++) begin
            if (c[p]) begin
                s = s ^ R'(p + 1);
            end
        end

        // The syndrome value is the 1-based position of the bad bit.
        c_corr = c;
        if (s != '0) begin
            c_corr[s - 4'd1] = ~c[s - 4'd1];
        end

        d = '0;
        for (int i = 0; i < K; i++) begin
            d[i] = c_corr[POS_DADO[i] - 4'd1];
        end

        corrigido = (s != '0);
    end

endmodule

// File: rtl/receptor_serial_hamming.sv
// receptor_serial_hamming
// Serial Hamming(15,11) receiver: deframes start bit, 15 code bits (LSB
// first) and stop bit from a single idle-high line, corrects single-bit
// errors and holds the 11 data bits in a one-entry output buffer.
//   clk          in  1   clock, rising edge
//   rst          in  1   asynchronous active-high reset
//   serial_in    in  1   serial line, idle high
//   pronto       in  1   consumer ready
//   dado         out 11  corrected data word
//   valido       out 1   dado holds an unconsumed word
//   corrigido    out 1   qualifies dado: a single-bit error was corrected
//   erro_quadro  out 1   one-cycle pulse: stop bit low, frame dropped
//   sobrecarga   out 1   one-cycle pulse: good frame dropped, buffer full
//
// Output handshake: a word transfers on a rising edge where valido=1 and
// pronto=1. dado/corrigido hold steady while valido=1. A load in the same
// edge as a transfer wins: valido stays 1 and the new word is presented.
// The line itself is never back-pressured; a word arriving while the buffer
// is occupied (and not being drained that cycle) is dropped with sobrecarga.
//
// The FSM state is kept in `estado` so checkers can bind to it directly.
module receptor_serial_hamming
    import hamming_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_in,
    input  logic          pronto,
    output logic [K-1:0]  dado,
    output logic          valido,
    output logic          corrigido,
    output logic          erro_quadro,
    output logic          sobrecarga
);

    localparam int TW = $clog2(CICLOS_POR_BIT);
    // Terminal counts for the half-bit start re-check and full-bit sampling.
    localparam logic [TW-1:0] TICK_MEIO = TW'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_BIT  = TW'(CICLOS_POR_BIT - 1);

    estado_t       estado;
    logic [TW-1:0] tick;
    logic [3:0]    cont_bits;
    logic [N-1:0]  c;

    logic [R-1:0]  sindrome;
    logic [K-1:0]  dado_corr;
    logic          corr;

    sindrome_hamming u_sindrome (
        .c         (c),
        .s         (sindrome),
        .d         (dado_corr),
        .corrigido (corr)
    );

    // serial_in is used directly: the sampling points are defined relative to
    // the first clock that sees the line low, so no extra synchronizer delay
    // is inserted here. The source is expected to be in this clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= OCIOSO;
            tick        <= '0;
            cont_bits   <= '0;
            c           <= '0;
            dado        <= '0;
            valido      <= 1'b0;
            corrigido   <= 1'b0;
            erro_quadro <= 1'b0;
            sobrecarga  <= 1'b0;
        end else begin
            erro_quadro <= 1'b0;
            sobrecarga  <= 1'b0;

            // Drain; a CORRIGE load below overrides this in the same cycle.
            if (valido && pronto) begin
                valido <= 1'b0;
            end

            case (estado)
                OCIOSO: begin
                    if (!serial_in) begin
                        estado <= INICIO;
                        tick   <= '0;
                    end
                end

                INICIO: begin
                    if (tick == TICK_MEIO) begin
                        tick      <= '0;
                        cont_bits <= '0;
                        // A line back high at mid-start-bit is a glitch.
                        estado    <= serial_in ? OCIOSO : DADOS;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                DADOS: begin
                    if (tick == TICK_BIT) begin
                        tick <= '0;
                        // Shift in from the top so the first bit ends in c[0].
                        c    <= {serial_in, c[N-1:1]};
                        if (cont_bits == 4'(N - 1)) begin
                            estado <= PARADA;
                        end else begin
                            cont_bits <= cont_bits + 4'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                PARADA: begin
                    if (tick == TICK_BIT) begin
                        tick <= '0;
                        if (serial_in) begin
                            estado <= CORRIGE;
                        end else begin
                            erro_quadro <= 1'b1;
                            estado      <= OCIOSO;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                CORRIGE: begin
                    estado <= OCIOSO;
                    if (!valido || pronto) begin
                        dado      <= dado_corr;
                        corrigido <= corr;
                        valido    <= 1'b1;
                    end else begin
                        sobrecarga <= 1'b1;
                    end
                end

                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // The decoder's correction flag must agree with its own syndrome.
    a_corr_sindrome: assert property (
        @(posedge clk) disable iff (rst) corr == (sindrome != '0)
    );

endmodule

// File: tb/tb_receptor_serial_hamming.sv
// tb_receptor_serial_hamming
// Self-checking bench for receptor_serial_hamming with CICLOS_POR_BIT=4.
// Frames are driven bit-serially; expected words come from a behavioural
// Hamming encode/decode model built from the position arithmetic.
module tb_receptor_serial_hamming;

    localparam int CPB = 4;
    localparam int H   = CPB / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_in;
    logic        pronto;
    logic [10:0] dado;
    logic        valido;
    logic        corrigido;
    logic        erro_quadro;
    logic        sobrecarga;

    int checks   = 0;
    int failures = 0;

    // Monitor state: written only by the monitor process.
    int          cyc     = 0;
    int          n_erro  = 0;
    int          n_sobre = 0;
    logic [11:0] got_q[$];          // {corrigido, dado} of every consumed word

    // Scoreboard state: written only by the test sequence.
    logic [11:0] exp_q[$];
    int          got_rd = 0;

    receptor_serial_hamming #(.CICLOS_POR_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .pronto      (pronto),
        .dado        (dado),
        .valido      (valido),
        .corrigido   (corrigido),
        .erro_quadro (erro_quadro),
        .sobrecarga  (sobrecarga)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (valido && pronto) got_q.push_back({corrigido, dado});
            if (erro_quadro) n_erro <= n_erro + 1;
            if (sobrecarga)  n_sobre <= n_sobre + 1;
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- reference model ----------------
    function automatic logic [14:0] encode(input logic [10:0] dd);
        logic [14:0] cw;
        logic        par;
        int          di;
        cw = '0;
        di = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p - 1] = dd[di];
                di++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++) begin
                if (((p >> i) & 1) == 1 && p != (1 << i)) par = par ^ cw[p - 1];
            end
            cw[(1 << i) - 1] = par;
        end
        return cw;
    endfunction

    function automatic logic [11:0] decode(input logic [14:0] cw_in);
        logic [14:0] cw;
        logic [3:0]  s;
        logic [10:0] dd;
        int          di;
        cw = cw_in;
        s  = '0;
        for (int p = 1; p <= 15; p++) begin
            if (cw[p - 1]) s = s ^ 4'(p);
        end
        if (s != 4'd0) cw[s - 4'd1] = ~cw[s - 4'd1];
        dd = '0;
        di = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                dd[di] = cw[p - 1];
                di++;
            end
        end
        return {(s != 4'd0), dd};
    endfunction

    // ---------------- driver tasks ----------------
    // All driving happens 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Must be called 1 unit after an edge; returns 1 unit after the edge
    // that ends the stop bit, so calls can be chained back-to-back.
    task automatic send_frame(input logic [14:0] cw, input logic stop_bit);
        serial_in = 1'b0;
        step(CPB);
        for (int k = 0; k < 15; k++) begin
            serial_in = cw[k];
            step(CPB);
        end
        serial_in = stop_bit;
        step(CPB);
        serial_in = 1'b1;
    endtask

    task automatic check_scoreboard(input string name);
        logic [11:0] e;
        logic [11:0] g;
        checks++;
        if (got_q.size() - got_rd != exp_q.size()) begin
            failures++;
            $display("FAIL %s count: got %0d words, expected %0d", name, got_q.size() - got_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && got_rd < got_q.size()) begin
            e = exp_q.pop_front();
            g = got_q[got_rd];
            got_rd++;
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s word: got corr=%0b dado=%03h, expected corr=%0b dado=%03h",
                         name, g[11], g[10:0], e[11], e[10:0]);
            end
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b1; pronto = 1'b0;
        step(3);
        checks++; if (dado !== 11'h000)    begin failures++; $display("FAIL reset_dado got=%03h exp=000", dado); end
        checks++; if (valido !== 1'b0)     begin failures++; $display("FAIL reset_valido got=%0b exp=0", valido); end
        checks++; if (corrigido !== 1'b0)  begin failures++; $display("FAIL reset_corrigido got=%0b exp=0", corrigido); end
        checks++; if (erro_quadro !== 1'b0) begin failures++; $display("FAIL reset_erro_quadro got=%0b exp=0", erro_quadro); end
        checks++; if (sobrecarga !== 1'b0) begin failures++; $display("FAIL reset_sobrecarga got=%0b exp=0", sobrecarga); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_clean();
        int s, ts, e0, s0;
        pronto = 1'b1;
        e0 = n_erro; s0 = n_sobre;
        s  = cyc;
        ts = s + 1 + H + 16 * CPB;
        exp_q.push_back(12'h001);
        fork
            send_frame(15'h0007, 1'b1);
            begin
                wait_to(ts);
                checks++; if (valido !== 1'b0) begin failures++; $display("FAIL clean_latency_early valido got=%0b exp=0", valido); end
                wait_to(ts + 1);
                checks++; if (valido !== 1'b1)    begin failures++; $display("FAIL clean_valido got=%0b exp=1", valido); end
                checks++; if (dado !== 11'h001)   begin failures++; $display("FAIL clean_dado got=%03h exp=001", dado); end
                checks++; if (corrigido !== 1'b0) begin failures++; $display("FAIL clean_corrigido got=%0b exp=0", corrigido); end
                wait_to(ts + 2);
                checks++; if (valido !== 1'b0)    begin failures++; $display("FAIL clean_one_cycle valido got=%0b exp=0", valido); end
            end
        join
        exp_q.push_back(12'h7FF);
        send_frame(15'h7FFF, 1'b1);
        step(3);
        check_scoreboard("clean");
        checks++; if (n_erro != e0 || n_sobre != s0) begin failures++; $display("FAIL clean_flags got erro=%0d sobre=%0d exp erro=%0d sobre=%0d", n_erro, n_sobre, e0, s0); end
    endtask

    task automatic test_single_error();
        logic [14:0] base;
        pronto = 1'b1;
        exp_q.push_back(12'h801);
        send_frame(15'h0027, 1'b1);
        base = encode(11'h7FF);
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(12'hFFF);
            send_frame(base ^ (15'h0001 << i), 1'b1);
        end
        step(3);
        check_scoreboard("single_error");
    endtask

    task automatic test_random();
        logic [14:0] cw;
        logic [10:0] dd;
        int          mode, s0, e0;
        pronto = 1'b1;
        s0 = n_sobre; e0 = n_erro;
        for (int n = 0; n < 24; n++) begin
            dd   = 11'($urandom);
            mode = $urandom_range(0, 2);
            cw   = encode(dd);
            if (mode == 1) cw = cw ^ (15'h0001 << $urandom_range(0, 14));
            if (mode == 2) cw = 15'($urandom);
            exp_q.push_back(decode(cw));
            send_frame(cw, 1'b1);
            step($urandom_range(0, 3));
        end
        step(3);
        check_scoreboard("random");
        checks++; if (n_erro != e0 || n_sobre != s0) begin failures++; $display("FAIL random_flags got erro=%0d sobre=%0d exp erro=%0d sobre=%0d", n_erro, n_sobre, e0, s0); end
    endtask

    task automatic test_framing();
        int s, ts, e0, s0;
        logic [10:0] dd;
        pronto = 1'b1;
        e0 = n_erro; s0 = n_sobre;
        s  = cyc;
        ts = s + 1 + H + 16 * CPB;
        fork
            send_frame(encode(11'($urandom)), 1'b0);
            begin
                wait_to(ts);
                checks++; if (erro_quadro !== 1'b1) begin failures++; $display("FAIL frame_err_pulse got=%0b exp=1", erro_quadro); end
                wait_to(ts + 1);
                checks++; if (erro_quadro !== 1'b0) begin failures++; $display("FAIL frame_err_width got=%0b exp=0", erro_quadro); end
                checks++; if (valido !== 1'b0)      begin failures++; $display("FAIL frame_err_valido got=%0b exp=0", valido); end
            end
        join
        step(3);
        checks++; if (n_erro != e0 + 1) begin failures++; $display("FAIL frame_err_count got=%0d exp=%0d", n_erro, e0 + 1); end
        check_scoreboard("frame_err_nodata");

        // One-cycle low glitch while idle.
        serial_in = 1'b0;
        step(1);
        serial_in = 1'b1;
        step(20 * CPB);
        checks++; if (n_erro != e0 + 1 || n_sobre != s0) begin failures++; $display("FAIL glitch_flags got erro=%0d sobre=%0d exp erro=%0d sobre=%0d", n_erro, n_sobre, e0 + 1, s0); end
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL glitch_valido got=%0b exp=0", valido); end
        dd = 11'($urandom);
        exp_q.push_back({1'b0, dd});
        send_frame(encode(dd), 1'b1);
        step(3);
        check_scoreboard("after_glitch");
    endtask

    task automatic test_back_pressure();
        int s, ts2, s0;
        pronto = 1'b0;
        s0  = n_sobre;
        s   = cyc;
        ts2 = s + 17 * CPB + 1 + H + 16 * CPB;
        fork
            begin
                send_frame(15'h0007, 1'b1);
                send_frame(15'h7FFF, 1'b1);
            end
            begin
                wait_to(ts2 + 1);
                checks++; if (sobrecarga !== 1'b1) begin failures++; $display("FAIL bp_sobre_pulse got=%0b exp=1", sobrecarga); end
                wait_to(ts2 + 2);
                checks++; if (sobrecarga !== 1'b0) begin failures++; $display("FAIL bp_sobre_width got=%0b exp=0", sobrecarga); end
            end
        join
        step(2);
        checks++; if (n_sobre != s0 + 1)  begin failures++; $display("FAIL bp_sobre_count got=%0d exp=%0d", n_sobre, s0 + 1); end
        checks++; if (valido !== 1'b1)    begin failures++; $display("FAIL bp_held_valido got=%0b exp=1", valido); end
        checks++; if (dado !== 11'h001)   begin failures++; $display("FAIL bp_held_dado got=%03h exp=001", dado); end
        checks++; if (corrigido !== 1'b0) begin failures++; $display("FAIL bp_held_corrigido got=%0b exp=0", corrigido); end
        exp_q.push_back(12'h001);
        pronto = 1'b1;
        step(1);
        checks++; if (valido !== 1'b0) begin failures++; $display("FAIL bp_drain_valido got=%0b exp=0", valido); end
        step(2);
        check_scoreboard("back_pressure");
    endtask

    task automatic test_simultaneous();
        int s, ts, s0;
        logic [10:0] da, db;
        logic [14:0] cwb;
        logic [11:0] eb;
        pronto = 1'b0;
        s0 = n_sobre;
        da = 11'($urandom);
        db = 11'($urandom);
        cwb = encode(db) ^ (15'h0001 << $urandom_range(0, 14));
        eb  = decode(cwb);
        send_frame(encode(da), 1'b1);
        step(2);
        s  = cyc;
        ts = s + 1 + H + 16 * CPB;
        exp_q.push_back({1'b0, da});
        fork
            send_frame(cwb, 1'b1);
            begin
                wait_to(ts);
                pronto = 1'b1;
                wait_to(ts + 1);
                pronto = 1'b0;
                checks++; if (valido !== 1'b1)       begin failures++; $display("FAIL simul_valido got=%0b exp=1", valido); end
                checks++; if (dado !== eb[10:0])     begin failures++; $display("FAIL simul_dado got=%03h exp=%03h", dado, eb[10:0]); end
                checks++; if (corrigido !== eb[11])  begin failures++; $display("FAIL simul_corrigido got=%0b exp=%0b", corrigido, eb[11]); end
                checks++; if (sobrecarga !== 1'b0)   begin failures++; $display("FAIL simul_sobre got=%0b exp=0", sobrecarga); end
            end
        join
        step(2);
        checks++; if (n_sobre != s0) begin failures++; $display("FAIL simul_sobre_count got=%0d exp=%0d", n_sobre, s0); end
        exp_q.push_back(eb);
        pronto = 1'b1;
        step(3);
        check_scoreboard("simultaneous");
    endtask

    task automatic test_reset_mid();
        logic [10:0] da, dc;
        logic [14:0] cw;
        int e0, s0;
        pronto = 1'b0;
        da = 11'($urandom) | 11'h001;
        send_frame(encode(da), 1'b1);
        step(2);
        e0 = n_erro; s0 = n_sobre;
        // Second frame, interrupted while bit 7 is on the line.
        cw = encode(11'($urandom));
        serial_in = 1'b0;
        step(CPB);
        for (int k = 0; k < 7; k++) begin
            serial_in = cw[k];
            step(CPB);
        end
        serial_in = cw[7];
        step(1);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dado !== 11'h000)     begin failures++; $display("FAIL rstmid_dado got=%03h exp=000", dado); end
        checks++; if (valido !== 1'b0)      begin failures++; $display("FAIL rstmid_valido got=%0b exp=0", valido); end
        checks++; if (corrigido !== 1'b0)   begin failures++; $display("FAIL rstmid_corrigido got=%0b exp=0", corrigido); end
        checks++; if (erro_quadro !== 1'b0) begin failures++; $display("FAIL rstmid_erro got=%0b exp=0", erro_quadro); end
        checks++; if (sobrecarga !== 1'b0)  begin failures++; $display("FAIL rstmid_sobre got=%0b exp=0", sobrecarga); end
        serial_in = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        exp_q.delete();
        got_rd = got_q.size();
        pronto = 1'b1;
        dc = 11'($urandom);
        exp_q.push_back({1'b0, dc});
        send_frame(encode(dc), 1'b1);
        step(3);
        check_scoreboard("after_reset_mid");
        checks++; if (n_erro != e0 || n_sobre != s0) begin failures++; $display("FAIL rstmid_flags got erro=%0d sobre=%0d exp erro=%0d sobre=%0d", n_erro, n_sobre, e0, s0); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1; serial_in = 1'b1; pronto = 1'b0;
        test_reset();
        test_clean();
        test_single_error();
        test_random();
        test_framing();
        test_back_pressure();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receptor_serial_hamming.md
# receptor_serial_hamming

Serial receiver for the Hamming(15,11) link. It deframes one codeword from a single-wire line: start bit, 15 code bits LSB first, then a stop bit. It then computes the syndrome, corrects any single-bit error, and presents the 11 data bits on a one-entry valid/ready output buffer. It sits between the serial channel (downstream of encoder and error injector) and the data consumer.

## Interface
- CICLOS_POR_BIT, 4, clock cycles per serial bit; legal range ≥2
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- serial_in  in  1  serial line, idle high
- pronto  in  1  consumer ready
- dado  out  11  corrected data word d[10:0]
- valido  out  1  dado holds an unconsumed word
- corrigido  out  1  qualifies dado: a single-bit error was corrected
- erro_quadro  out  1  one-cycle pulse: stop bit sampled low, frame dropped
- sobrecarga  out  1  one-cycle pulse: good frame dropped because buffer full

## Operation
- Codeword map: c[p-1] holds position p=1..15.
  - Parity bits sit at p=1,2,4,8.
  - d[0..10] sit at p=3,5,6,7,9,10,11,12,13,14,15, in that order.
- Syndrome s[3:0] = XOR of all p where c[p-1]=1.
  - s≠0: flip c[s-1] and set corrigido.
  - s=0: no flip, corrigido=0.
  - Double errors are not detected; they are miscorrected silently.
- States:
  - OCIOSO: waits for serial_in=0, then goes to INICIO with the tick counter cleared.
  - INICIO: after CICLOS_POR_BIT/2 (floor) cycles, re-samples the line.
    - Low: go to DADOS.
    - High: false start, return to OCIOSO with no flags.
  - DADOS: every CICLOS_POR_BIT cycles, samples one bit into shift register c.
    - c[0] is received first.
    - A 4-bit counter counts 0..14. After the 15th sample, go to PARADA.
  - PARADA: samples the stop bit CICLOS_POR_BIT cycles after the last data bit.
    - 1: go to CORRIGE.
    - 0: pulse erro_quadro and go to OCIOSO.
  - CORRIGE: one cycle.
    - If the buffer is free, or pronto=1 in this same cycle: load dado/corrigido and set valido.
    - Otherwise: pulse sobrecarga and discard the word; the buffered word is untouched.
    - Next state is OCIOSO.
- Handshake:
  - A word is consumed on a rising edge with valido=1 and pronto=1.
  - dado and corrigido are stable while valido=1.
  - If consume and load happen in the same cycle, the load wins: valido stays 1 and the new word is shown.
- Reception is not gated by pronto; the line is never back-pressured.
- Reset mid-frame abandons the frame and asserts no flags.

## Timing
- Reset values: dado=0, valido=0, corrigido=0, erro_quadro=0, sobrecarga=0, state OCIOSO, counters 0.
- Sampling points are measured from the first clock at which a low serial_in is seen in OCIOSO:
  - start re-check at +CICLOS_POR_BIT/2
  - data bit k at +CICLOS_POR_BIT/2 + (k+1)·CICLOS_POR_BIT, for k=0..14
  - stop bit at +CICLOS_POR_BIT/2 + 16·CICLOS_POR_BIT
- Latency: valido, or the sobrecarga pulse, appears 2 clocks after the stop-bit sampling edge.
- erro_quadro pulses the cycle after the stop-bit sampling edge.
- Flag pulses are exactly one cycle wide.
- A new start bit is accepted one cycle after CORRIGE (or PARADA on error). Back-to-back frames with a one-bit-time stop bit are therefore never missed.
- Output registers are driven only from flops; there is no combinational path from pronto to any output.

## Structure
- Package hamming_pkg holds:
  - constants N=15, K=11, R=4
  - the data-position table above
  - the state enum
- Sub-module sindrome_hamming (combinational): takes c[14:0] and returns s[3:0], corrected data d[10:0] and the corrigido bit.
- The top holds the FSM, tick and bit counters, shift register and output buffer.

## Test plan
- Clean frame, CICLOS_POR_BIT=4:
  - data 0x001 sent as codeword 0x0007, pronto=1 → dado=0x001, corrigido=0, valido one cycle.
  - Also codeword 0x7FFF → dado=0x7FF.
- Single error: codeword 0x0027 (position 6 flipped) → dado=0x001, corrigido=1. Sweep all 15 flip positions on data 0x7FF; every one yields 0x7FF with corrigido=1.
- Framing:
  - stop bit driven 0 → erro_quadro pulse, valido stays 0
  - 1-cycle low glitch in OCIOSO → returns to OCIOSO, no flags
- Back-pressure: pronto=0, two back-to-back frames 0x0007 then 0x7FFF → first word held, sobrecarga pulses once, dado stays 0x001. Then pronto=1 → consumed, valido=0.
- Simultaneous consume/load: pronto asserted exactly in the CORRIGE cycle of the second frame → valido stays 1, dado becomes the second word, no sobrecarga.
- Reset mid-frame:
  - assert rst during DADOS bit 7 → all outputs 0 immediately (async)
  - after release, a full new frame decodes correctly
